// File: rtl/uart_tx_frame_if.sv
// Parallel-side handshake and serial output bundle for the UART frame transmitter.
// The slave modport is the transmitter; the master modport is the data source.
interface uart_tx_frame_if;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] prescale;
  logic       TX_OUT;
  logic       busy;
  logic       frame_done;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale,
    input  TX_OUT, busy, frame_done
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale,
    output TX_OUT, busy, frame_done
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, one stop bit.
// Each bit lasts 'prescale' clocks; all frame options are latched on the accept edge.
module uart_tx_frame (
  input  logic           clk,
  input  logic           rst,
  uart_tx_frame_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e     state_q;
  logic [5:0] cnt_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] data_q;
  logic       par_en_q;
  logic       par_bit_q;
  logic [5:0] presc_q;
  logic       tx_q;
  logic       busy_q;
  logic       frame_done_q;
  logic       bit_end;

  // presc_q is forced to at least 1 on accept, so the subtraction never wraps while busy.
  assign bit_end = (cnt_q == presc_q - 6'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      data_q       <= '0;
      par_en_q     <= 1'b0;
      par_bit_q    <= 1'b0;
      presc_q      <= 6'd1;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (bus.DATA_VALID) begin
            data_q    <= bus.P_DATA;
            par_en_q  <= bus.PAR_EN;
            par_bit_q <= (^bus.P_DATA) ^ bus.PAR_TYP;
            presc_q   <= (bus.prescale == 6'd0) ? 6'd1 : bus.prescale;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= StStart;
          end
        end
        StStart: begin
          if (bit_end) begin
            cnt_q   <= '0;
            tx_q    <= data_q[0];
            state_q <= StData;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        StData: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_q <= '0;
              if (par_en_q) begin
                tx_q    <= par_bit_q;
                state_q <= StParity;
              end else begin
                tx_q    <= 1'b1;
                state_q <= StStop;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              tx_q      <= data_q[bit_cnt_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        StParity: begin
          if (bit_end) begin
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        StStop: begin
          if (bit_end) begin
            cnt_q        <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
            state_q      <= StIdle;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.TX_OUT     = tx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Serial UART transmitter that converts one parallel byte into a framed bit stream: start bit, 8 data bits LSB first, optional parity bit, and one stop bit. Each bit is held on the line for `prescale` system clock cycles, so the timing matches the receiver's oversampling ratio without a separate baud clock. The block sits on the transmit side of the UART pair, between the system data source and the serial line. Its framing options are the same ones the receive path checks.

## Interface
- No parameters; data width fixed at 8, frame format fixed as below.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `P_DATA`  in  8  byte to transmit; sampled only on the accept cycle.
- `DATA_VALID`  in  1  request to send `P_DATA`; honoured only while in IDLE.
- `PAR_EN`  in  1  1 = insert parity bit; sampled on the accept cycle.
- `PAR_TYP`  in  1  0 = even parity, 1 = odd parity; sampled on the accept cycle.
- `prescale`  in  6  clk cycles per serial bit; sampled on the accept cycle; 0 treated as 1.
- `TX_OUT`  out  1  serial line, registered; idles high.
- `busy`  out  1  high while a frame is in flight, registered.
- `frame_done`  out  1  one-cycle pulse on the first IDLE cycle after a stop bit, registered.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE behaviour: `TX_OUT`=1, `busy`=0.
- Accept: IDLE with `DATA_VALID`=1 at a rising edge.
  - Latches `P_DATA`, `PAR_EN`, `PAR_TYP` and the effective prescale P.
  - Computes parity bit = ^P_DATA XOR PAR_TYP.
  - Moves to START.
- START: `TX_OUT`=0 for P cycles, then DATA.
- DATA: bit index 0..7, LSB first, each bit held P cycles.
  - After bit 7: PARITY if latched PAR_EN=1, else STOP.
- PARITY: `TX_OUT`=parity bit for P cycles, then STOP.
- STOP: `TX_OUT`=1 for P cycles, then IDLE with `frame_done`=1 for one cycle.
- Counters:
  - cycle counter is 6 bits, counts 0..P-1, and wraps to 0 at each bit boundary.
  - bit counter is 3 bits, counts 0..7, and wraps only on the DATA→PARITY/STOP transition.
- `busy`=1 in every non-IDLE state.
- `DATA_VALID` while `busy`=1 is ignored. No queueing, no error flag.
- Input changes mid-frame have no effect, because the frame uses latched copies.
- Changing `P_DATA`/`prescale`/`PAR_EN`/`PAR_TYP` on the accept cycle is legal; the value present at that edge is used.
- Reset (any state, including mid-bit):
  - Next cycle: `TX_OUT`=1, `busy`=0, `frame_done`=0, state IDLE.
  - Counters and latched data are cleared; the partial frame is abandoned.
  - No `frame_done` is produced for the abandoned frame.
- Reset values: `TX_OUT`=1, `busy`=0, `frame_done`=0.

## Timing
- Accept edge N:
  - `busy`=1 and `TX_OUT`=0 (start) from cycle N+1.
  - Start bit occupies cycles N+1..N+P.
  - Data bit k occupies cycles N+1+(k+1)P .. N+(k+2)P.
- Frame length L = (10 + PAR_EN)·P cycles: cycles N+1..N+L carry the frame.
  - Cycle N+L+1 is IDLE with `busy`=0 and `frame_done`=1.
- Back-to-back: `DATA_VALID` held high is accepted at edge N+L+1.
  - Minimum inter-frame gap is 1 idle-high cycle, appended to the stop bit.
- P=1: every state lasts one cycle; 10/11-cycle frame.
- P=63 (max): 630/693-cycle frame.
- `TX_OUT` is glitch-free: driven from a flop, changes only at bit boundaries.

## Test plan
- Reset state:
  - Stimulus: assert `rst` 3 cycles, then release with `DATA_VALID`=0.
  - Required: `TX_OUT`=1, `busy`=0, `frame_done`=0, held for 20 cycles.
- Even-parity frame:
  - Stimulus: `P_DATA`=0xA5, `PAR_EN`=1, `PAR_TYP`=0, `prescale`=8, one-cycle `DATA_VALID`.
  - Required line sequence, 8 cycles per bit: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1.
  - `busy` high exactly 88 cycles, then `frame_done` pulse.
- Odd parity / no parity with minimum prescale:
  - Stimulus: same byte, `PAR_TYP`=1, `prescale`=1; parity bit must be 1 (11-cycle frame).
  - Then `PAR_EN`=0, `prescale`=0; frame must be 10 cycles with no parity bit.
- Back-to-back and ignored requests:
  - Stimulus: `DATA_VALID` held high, `P_DATA` 0x00 then 0xFF, `prescale`=16, `PAR_EN`=0.
  - Required: two frames separated by exactly one idle-high cycle.
  - Pulsing `DATA_VALID` mid-frame with 0x3C must not alter the stream.
- Mid-frame reset:
  - Stimulus: assert `rst` during data bit 3 at `prescale`=16.
  - Required: `TX_OUT`=1 and `busy`=0 the next cycle, with no `frame_done`.
  - A new request afterwards must produce a complete, correct frame starting from the start bit.
- Input stability:
  - Stimulus: change `P_DATA` and `prescale` every cycle during a frame.
  - Required: line output matches the values latched at the accept edge.
